// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: turns debounced button levels into press events and
// runs the STOP/RUN/CLEAR machine. Define STOPWATCH_LAP_EN to enable lap hold.
module stopwatch_cu (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_run,
  input  logic i_btn_clear,
  input  logic i_btn_mode,
  output logic o_run,
  output logic o_clear,
  output logic o_mode,
  output logic o_lap
);

  typedef enum logic [1:0] {
    STOP    = 2'b00,
    RUN     = 2'b01,
    CLEAR   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  logic prev_run;
  logic prev_clear;
  logic prev_mode;
  logic run_evt;
  logic clear_evt;
  logic mode_evt;
  logic mode_q;

  // History resets to 1 so a button held through reset needs a fresh press.
  assign run_evt   = i_btn_run   & ~prev_run;
  assign clear_evt = i_btn_clear & ~prev_clear;
  assign mode_evt  = i_btn_mode  & ~prev_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_run   <= 1'b1;
      prev_clear <= 1'b1;
      prev_mode  <= 1'b1;
      mode_q     <= 1'b0;
    end else begin
      prev_run   <= i_btn_run;
      prev_clear <= i_btn_clear;
      prev_mode  <= i_btn_mode;
      if (mode_evt) begin
        mode_q <= ~mode_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Run wins over clear in STOP; the losing clear event is simply dropped.
  always_comb begin
    state_nxt = STOP;
    case (state)
      STOP: begin
        if (run_evt) begin
          state_nxt = RUN;
        end else if (clear_evt) begin
          state_nxt = CLEAR;
        end else begin
          state_nxt = STOP;
        end
      end
      RUN: begin
        if (run_evt) begin
          state_nxt = STOP;
        end else begin
          state_nxt = RUN;
        end
      end
      CLEAR:   state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q;

  // Lap toggles only while RUN stays RUN; a stop press leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q <= 1'b0;
    end else if (state_nxt == CLEAR) begin
      lap_q <= 1'b0;
    end else if ((state == RUN) && clear_evt && !run_evt) begin
      lap_q <= ~lap_q;
    end
  end
`endif

  always_comb begin
    o_run   = (state == RUN);
    o_clear = (state == CLEAR);
    o_mode  = mode_q;
`ifdef STOPWATCH_LAP_EN
    o_lap   = lap_q;
`else
    o_lap   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_stopwatch_cu.sv
// Self-checking bench for stopwatch_cu: behavioural model compared every cycle,
// plus literal expectations pinned at key points of the directed sequence.
module tb_stopwatch_cu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_btn_run = 1'b0;
  logic i_btn_clear = 1'b0;
  logic i_btn_mode = 1'b0;
  logic o_run, o_clear, o_mode, o_lap;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_cu dut (
    .clk(clk), .rst(rst),
    .i_btn_run(i_btn_run), .i_btn_clear(i_btn_clear), .i_btn_mode(i_btn_mode),
    .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode), .o_lap(o_lap)
  );

  // Behavioural model: "running", "clearing this cycle", display mode, lap.
  bit m_running, m_clearing, m_mode, m_lap, started;
  bit h_run, h_clear, h_mode;

  always @(posedge clk) begin
    bit pr, pc, pm;
    if (rst) begin
      m_running = 0; m_clearing = 0; m_mode = 0; m_lap = 0;
      h_run = 1; h_clear = 1; h_mode = 1;
    end else begin
      pr = i_btn_run && !h_run;
      pc = i_btn_clear && !h_clear;
      pm = i_btn_mode && !h_mode;
      if (m_clearing) begin
        m_clearing = 0;
      end else if (!m_running) begin
        if (pr) m_running = 1;
        else if (pc) begin m_clearing = 1; m_lap = 0; end
      end else begin
        if (pr) m_running = 0;
`ifdef STOPWATCH_LAP_EN
        else if (pc) m_lap = !m_lap;
`endif
      end
      if (pm) m_mode = !m_mode;
      h_run = i_btn_run; h_clear = i_btn_clear; h_mode = i_btn_mode;
    end
    started = 1;
  end

  // Literal expectation requested by the stimulus for the coming edge.
  bit    pin_on = 0;
  string pin_name = "";
  int    pin_sig = 0;
  logic  pin_val = 1'b0;

  task automatic check(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Single compare process, sampling 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      check("o_run", o_run, m_running);
      check("o_clear", o_clear, m_clearing);
      check("o_mode", o_mode, m_mode);
      check("o_lap", o_lap, m_lap);
      check("run_clear_exclusive", o_run & o_clear, 1'b0);
      if (pin_on) begin
        case (pin_sig)
          0: check(pin_name, o_run, pin_val);
          1: check(pin_name, o_clear, pin_val);
          2: check(pin_name, o_mode, pin_val);
          default: check(pin_name, o_lap, pin_val);
        endcase
      end
    end
  end

  task automatic cyc(input logic r, input logic c, input logic m);
    @(negedge clk);
    pin_on = 0;
    i_btn_run = r; i_btn_clear = c; i_btn_mode = m;
  endtask

  task automatic pin(input string nm, input int sig, input logic v);
    pin_name = nm; pin_sig = sig; pin_val = v; pin_on = 1;
  endtask

  initial begin
    // Reset with run held, then keep holding after release of reset.
    rst = 1;
    repeat (10) cyc(1, 0, 0);
    pin("reset_run", 0, 1'b0);
    @(negedge clk); pin_on = 0; rst = 0;
    repeat (5) cyc(1, 0, 0);
    pin("held_through_reset", 0, 1'b0);
    cyc(0, 0, 0);
    cyc(1, 0, 0); pin("first_press_run", 0, 1'b1);
    repeat (99) cyc(1, 0, 0);
    pin("hold_100_still_run", 0, 1'b1);
    cyc(0, 0, 0);
    cyc(1, 0, 0); pin("second_press_stop", 0, 1'b0);
    cyc(0, 0, 0);

    // Clear from STOP: one-cycle pulse.
    cyc(0, 1, 0); pin("clear_pulse", 1, 1'b1);
    cyc(0, 1, 0); pin("clear_pulse_end", 1, 1'b0);
    cyc(0, 1, 0); pin("clear_no_repeat", 1, 1'b0);
    cyc(0, 0, 0);

    // Clear while running.
    cyc(1, 0, 0); pin("run_again", 0, 1'b1);
    cyc(0, 0, 0);
    cyc(0, 1, 0); pin("clear_in_run_no_pulse", 1, 1'b0);
`ifdef STOPWATCH_LAP_EN
    cyc(0, 0, 0); pin("lap_set", 3, 1'b1);
`else
    cyc(0, 0, 0); pin("clear_in_run_keeps_run", 0, 1'b1);
`endif

    // Mode toggles while running.
    cyc(0, 0, 1); pin("mode_on", 2, 1'b1);
    cyc(0, 0, 0); pin("mode_run_kept", 0, 1'b1);
    cyc(0, 0, 1); pin("mode_off", 2, 1'b0);
    cyc(0, 0, 0);

    // Stop, then clear (lap forced low on clear when the feature exists).
    cyc(1, 0, 0); pin("stop", 0, 1'b0);
`ifdef STOPWATCH_LAP_EN
    cyc(0, 0, 0); pin("lap_kept_on_stop", 3, 1'b1);
`else
    cyc(0, 0, 0); pin("lap_tied_low", 3, 1'b0);
`endif
    cyc(0, 1, 0); pin("clear_after_stop", 1, 1'b1);
    cyc(0, 0, 0); pin("lap_cleared", 3, 1'b0);

    // Simultaneous run and clear in STOP: run wins.
    cyc(1, 1, 0); pin("simul_run", 0, 1'b1);
    cyc(1, 1, 0); pin("simul_no_clear", 1, 1'b0);
    cyc(0, 0, 0);

    // Mode in clock display, then reset mid-run with a pending mode press.
    cyc(0, 0, 1); pin("mode_on_2", 2, 1'b1);
    cyc(0, 0, 0);
    @(negedge clk); rst = 1; i_btn_mode = 1; pin("reset_mid_run", 0, 1'b0);
    @(negedge clk); pin_on = 0; rst = 0; pin("reset_mode", 2, 1'b0);
    cyc(0, 0, 1); pin("mode_held_after_reset", 2, 1'b0);
    cyc(0, 0, 0);
    cyc(0, 0, 1); pin("mode_after_reset", 2, 1'b1);
    repeat (3) cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
